// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate truth-table tester: gate function codes,
// controller state encoding and vector sizing.
package gate_test_pkg;

    localparam int NUM_VECTORS = 4;
    localparam int VEC_IDX_W   = 2;
    localparam int ERR_W       = 3;
    localparam int SETTLE_W    = 4;

    typedef enum logic [2:0] {
        FN_AND    = 3'd0,
        FN_NAND   = 3'd1,
        FN_OR     = 3'd2,
        FN_NOR    = 3'd3,
        FN_XOR    = 3'd4,
        FN_XNOR   = 3'd5,
        FN_NOT_A  = 3'd6,
        FN_BUF_A  = 3'd7
    } gate_func_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } tester_state_e;

    // True when idx addresses the final vector of a run.
    function automatic logic is_last_vector(input logic [VEC_IDX_W-1:0] idx);
        return idx == VEC_IDX_W'(NUM_VECTORS - 1);
    endfunction

endpackage

// File: rtl/gate_truth_table_tester_if.sv
// Probe bundle between the tester (drives a/b, reads x) and the gate under test.
interface gate_truth_table_tester_if;
    logic a;
    logic b;
    logic x;

    modport master (output a, output b, input x);
    modport slave  (input a, input b, output x);
endinterface

// File: rtl/gate_ref_model.sv
// Combinational golden value of the selected two-input gate function.
module gate_ref_model
    import gate_test_pkg::*;
(
    input  logic [2:0] func_sel,
    input  logic       a,
    input  logic       b,
    output logic       expected
);

    always_comb begin
        expected = 1'b0;
        case (gate_func_e'(func_sel))
            FN_AND:   expected = a & b;
            FN_NAND:  expected = ~(a & b);
            FN_OR:    expected = a | b;
            FN_NOR:   expected = ~(a | b);
            FN_XOR:   expected = a ^ b;
            FN_XNOR:  expected = ~(a ^ b);
            FN_NOT_A: expected = ~a;
            FN_BUF_A: expected = a;
            default:  expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_truth_table_tester.sv
// Walks the four {a,b} input vectors through a gate under test, waits a
// settle time for each, and records which outputs disagree with func_sel.
module gate_truth_table_tester
    import gate_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] func_sel,
    output logic       a,
    output logic       b,
    input  logic       x,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    // Terminal count of the settle counter; unused when SETTLE_CYCLES is 0.
    localparam logic [SETTLE_W-1:0] SETTLE_LAST =
        (SETTLE_CYCLES == 0) ? '0 : SETTLE_W'(SETTLE_CYCLES - 1);

    tester_state_e              state_q, state_d;
    logic [VEC_IDX_W-1:0]       idx_q, idx_d;
    logic [SETTLE_W-1:0]        cnt_q, cnt_d;
    gate_func_e                 func_q, func_d;
    logic [ERR_W-1:0]           err_q, err_d;
    logic [NUM_VECTORS-1:0]     fail_q, fail_d;

    logic                       exp_bit;
    logic                       mismatch;
    logic [NUM_VECTORS-1:0]     vec_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VECTORS; gi++) begin : g_onehot
            assign vec_onehot[gi] = (idx_q == VEC_IDX_W'(gi));
        end
    endgenerate

    gate_ref_model u_ref (
        .func_sel (func_q),
        .a        (a),
        .b        (b),
        .expected (exp_bit)
    );

    assign mismatch = (x != exp_bit);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            func_q  <= FN_AND;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            func_q  <= func_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        func_d  = func_q;
        err_d   = err_q;
        fail_d  = fail_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_APPLY;
                    func_d  = gate_func_e'(func_sel);
                    idx_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    fail_d  = '0;
                end
            end
            ST_APPLY: begin
                cnt_d   = '0;
                state_d = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + SETTLE_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    fail_d = fail_q | vec_onehot;
                    // Saturate: a run has only NUM_VECTORS chances to miss.
                    if (err_q != ERR_W'(NUM_VECTORS)) begin
                        err_d = err_q + ERR_W'(1);
                    end
                end
                if (is_last_vector(idx_q)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + VEC_IDX_W'(1);
                    state_d = ST_APPLY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done      = (state_q == ST_DONE);
    assign pass      = done && (err_q == '0);
    assign a         = busy & idx_q[1];
    assign b         = busy & idx_q[0];
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_truth_table_tester.sv
// Self-checking bench: two testers (settle 2 and settle 0) probing behavioural gates.
module tb_gate_truth_table_tester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start0, start1;
    logic [2:0] func_sel;
    logic [3:0] dev0, dev1;
    logic [1:0] busy_w, done_w, pass_w;
    logic [2:0] err_w  [2];
    logic [3:0] fail_w [2];

    int errors = 0;
    int checks = 0;

    gate_truth_table_tester_if gif0 ();
    gate_truth_table_tester_if gif1 ();

    // Behavioural devices: dev is the truth table indexed by {a,b}.
    assign gif0.x = dev0[{gif0.a, gif0.b}];
    assign gif1.x = dev1[{gif1.a, gif1.b}];

    gate_truth_table_tester #(.SETTLE_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .func_sel(func_sel),
        .a(gif0.a), .b(gif0.b), .x(gif0.x),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(err_w[0]), .fail_vec(fail_w[0])
    );

    gate_truth_table_tester #(.SETTLE_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .func_sel(func_sel),
        .a(gif1.a), .b(gif1.b), .x(gif1.x),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(err_w[1]), .fail_vec(fail_w[1])
    );

    typedef struct {
        logic [2:0] f;
        logic [3:0] dev;
        logic [3:0] exp_fail;
        logic [2:0] exp_err;
    } vec_t;

    vec_t tbl [8];

    // Truth table of each function code, bit i = output for {a,b} = i.
    function automatic logic [3:0] func_tt(input logic [2:0] f);
        case (f)
            3'd0:    return 4'b1000;
            3'd1:    return 4'b0111;
            3'd2:    return 4'b1110;
            3'd3:    return 4'b0001;
            3'd4:    return 4'b0110;
            3'd5:    return 4'b1001;
            3'd6:    return 4'b0011;
            default: return 4'b1100;
        endcase
    endfunction

    function automatic logic [1:0] get_ab(input int d);
        return (d == 0) ? {gif0.a, gif0.b} : {gif1.a, gif1.b};
    endfunction

    function automatic logic [12:0] all_outs(input int d);
        return {busy_w[d], done_w[d], pass_w[d], err_w[d], fail_w[d], get_ab(d)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_start(input int d, input logic v);
        if (d == 0) start0 = v;
        else        start1 = v;
    endtask

    // Called at a negedge; launches a run and checks latency, a/b sequence and results.
    task automatic run_check(input int d, input logic [2:0] f, input logic [3:0] dev,
                             input logic [3:0] exp_fail, input logic [2:0] exp_err,
                             input bit mid_start, input string tag);
        int  s;
        int  cyc;
        bit  seq_ok;
        s = (d == 0) ? 2 : 0;
        if (d == 0) dev0 = dev;
        else        dev1 = dev;
        func_sel = f;
        set_start(d, 1'b1);
        @(negedge clk);
        set_start(d, 1'b0);
        cyc    = 0;
        seq_ok = 1'b1;
        while (done_w[d] !== 1'b1 && cyc < 200) begin
            if (mid_start && cyc == 5) begin
                set_start(d, 1'b1);
                func_sel = 3'd2;
            end else if (mid_start && cyc == 6) begin
                set_start(d, 1'b0);
            end
            if (busy_w[d] !== 1'b1 || get_ab(d) !== 2'(cyc / (s + 2))) seq_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        set_start(d, 1'b0);
        check({tag, ".latency"}, cyc, 4 * (s + 2));
        check({tag, ".ab_seq"}, 32'(seq_ok), 1);
        check({tag, ".fail_vec"}, fail_w[d], exp_fail);
        check({tag, ".err_count"}, err_w[d], exp_err);
        check({tag, ".pass"}, pass_w[d], (exp_fail == 4'b0000));
        check({tag, ".idle_ab_busy"}, {get_ab(d), busy_w[d]}, 3'b000);
        repeat (3) @(negedge clk);
        check({tag, ".hold"}, {done_w[d], err_w[d], fail_w[d]}, {1'b1, exp_err, exp_fail});
        $display("run %s dut%0d func=%0d dev=%b fail_vec=%b err=%0d pass=%0b cycles=%0d",
                 tag, d, f, dev, fail_w[d], err_w[d], pass_w[d], cyc);
    endtask

    initial begin
        tbl[0] = '{3'd0, 4'b1000, 4'b0000, 3'd0};
        tbl[1] = '{3'd1, 4'b1000, 4'b1111, 3'd4};
        tbl[2] = '{3'd4, 4'b1110, 4'b1000, 3'd1};
        tbl[3] = '{3'd2, 4'b1110, 4'b0000, 3'd0};
        tbl[4] = '{3'd3, 4'b0111, 4'b0110, 3'd2};
        tbl[5] = '{3'd5, 4'b1001, 4'b0000, 3'd0};
        tbl[6] = '{3'd7, 4'b0000, 4'b1100, 3'd2};
        tbl[7] = '{3'd6, 4'b1111, 4'b1100, 3'd2};

        rst = 1'b1;
        start0 = 1'b1;
        start1 = 1'b0;
        func_sel = 3'd0;
        dev0 = 4'b0000;
        dev1 = 4'b0000;
        repeat (3) @(negedge clk);
        check("reset_over_start.dut0", all_outs(0), 13'd0);
        start0 = 1'b0;
        @(negedge clk);
        check("reset.dut0", all_outs(0), 13'd0);
        check("reset.dut1", all_outs(1), 13'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_check(0, tbl[i].f, tbl[i].dev, tbl[i].exp_fail, tbl[i].exp_err, 1'b0,
                      $sformatf("tbl%0d", i));
        end

        run_check(1, 3'd6, 4'b0011, 4'b0000, 3'd0, 1'b0, "settle0_nota");
        run_check(0, 3'd0, 4'b1000, 4'b0000, 3'd0, 1'b1, "start_while_busy");

        // Abort during SETTLE of vector 2 after two mismatches have been logged.
        dev0 = 4'b1000;
        func_sel = 3'd1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (9) @(negedge clk);
        check("abort.pre", {busy_w[0], get_ab(0), err_w[0]}, {1'b1, 2'b10, 3'd2});
        rst = 1'b1;
        @(negedge clk);
        check("abort.cleared", all_outs(0), 13'd0);
        rst = 1'b0;
        @(negedge clk);
        run_check(0, 3'd1, 4'b1000, 4'b1111, 3'd4, 1'b0, "after_abort");

        for (int i = 0; i < 16; i++) begin
            int         d;
            logic [2:0] f;
            logic [3:0] dev;
            logic [3:0] ef;
            d   = int'($urandom_range(0, 1));
            f   = 3'($urandom_range(0, 7));
            dev = 4'($urandom_range(0, 15));
            ef  = func_tt(f) ^ dev;
            run_check(d, f, dev, ef, 3'($countones(ef)), 1'b0, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gate_truth_table_tester.md
GATE_TRUTH_TABLE_TESTER -- requirements
Module: gate_truth_table_tester

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning wait cycles between driving a vector and sampling x (legal range 0..15).
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, meaning reset: synchronous, active-high.
REQ-004 SHALL have port start, input, 1 bit, meaning a run request.
REQ-005 SHALL have port func_sel, input, 3 bits, meaning the expected gate function of the device under test.
REQ-006 SHALL have ports a and b, outputs, 1 bit each, meaning the stimulus driven to the gate-under-test inputs.
REQ-007 SHALL have port x, input, 1 bit, meaning the gate-under-test output.
REQ-008 SHALL have port busy, output, 1 bit, meaning a run is in progress.
REQ-009 SHALL have port done, output, 1 bit, meaning the results are valid.
REQ-010 SHALL have port pass, output, 1 bit, meaning all four vectors matched.
REQ-011 SHALL have port err_count, output, 3 bits, meaning the number of mismatching vectors (0..4).
REQ-012 SHALL have port fail_vec, output, 4 bits, meaning bit i set when vector i mismatched.

Function
REQ-013 func_sel encoding SHALL be: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 BUF a.
REQ-014 States SHALL be IDLE, APPLY, SETTLE, SAMPLE and DONE.
REQ-015 IDLE -> APPLY SHALL occur when start=1; func_sel SHALL be latched on that edge; vector index SHALL be set to 0; err_count and fail_vec SHALL be cleared.
REQ-016 Vector i SHALL drive {a,b} = i[1:0], in order 00, 01, 10, 11.
REQ-017 APPLY SHALL last exactly 1 cycle and then enter SETTLE; SETTLE SHALL last SETTLE_CYCLES cycles; with SETTLE_CYCLES=0, APPLY SHALL go directly to SAMPLE.
REQ-018 SAMPLE SHALL last 1 cycle, comparing x against the expected value of the latched function at the current {a,b}; on mismatch, fail_vec[i] SHALL be set and err_count incremented, both visible from the next edge.
REQ-019 SAMPLE SHALL go to APPLY with index+1 if index<3, else to DONE.
REQ-020 a and b SHALL hold the current vector throughout APPLY, SETTLE and SAMPLE, and SHALL be 0 in IDLE and DONE.
REQ-021 busy SHALL be 1 exactly in APPLY, SETTLE and SAMPLE.
REQ-022 done SHALL be 1 exactly in DONE.
REQ-023 pass SHALL equal (err_count==0) while done=1, and SHALL be 0 otherwise.
REQ-024 Latency: done SHALL rise 4*(SETTLE_CYCLES+2) cycles after the edge that accepted start (16 cycles at the default).
REQ-025 DONE SHALL hold results until start=1, which SHALL begin a new run exactly as from IDLE.
REQ-026 start while busy SHALL be ignored with no effect on the run or on latched func_sel.
REQ-027 func_sel changes during a run SHALL have no effect.
REQ-028 err_count SHALL NOT wrap; its maximum is 4.

Reset
REQ-029 rst=1 at a rising edge SHALL force IDLE with a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, settle counter=0 and index=0, and SHALL take priority over start.
REQ-030 rst asserted mid-run SHALL abort the run with no partial results retained.

Structure
REQ-031 The func_sel encoding, state encoding and vector count (4) SHALL reside in shared package gate_test_pkg.
REQ-032 The expected-value computation SHALL be one combinational sub-module, gate_ref_model (inputs func_sel, a, b; output expected).

Verification
REQ-033 func_sel=0, x wired to a AND b, SETTLE_CYCLES=2 -> done at cycle 16, pass=1, err_count=0, fail_vec=0000.
REQ-034 func_sel=1, x wired to a AND b -> err_count=4, fail_vec=1111, pass=0.
REQ-035 func_sel=4, x wired to a OR b -> only vector 11 mismatches: fail_vec=1000, err_count=1.
REQ-036 SETTLE_CYCLES=0, func_sel=6, x wired to NOT a -> done after 8 cycles, pass=1, with a/b sequence 00, 01, 10, 11, each held 2 cycles.
REQ-037 start pulsed again at cycle 5 with func_sel changed to 2 -> run unaffected; results match the original func_sel.
REQ-038 rst asserted during SETTLE of vector 2 -> next cycle IDLE, all outputs 0; a subsequent start runs the full 4 vectors from 00.
